uart_tx_buffered: RTL

- UART transmit peripheral: the transmit-side counterpart to the receive path that drives the debug LEDs.
- Accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames on uart_txd.
- Sits beside the UART receive peripheral in impl-level tops and is fed by button/switch logic or loop-back.
- One clock domain; no flow control pins.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx_buffered.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings and bit-timing helpers.
// The receive peripheral imports this too so both ends derive identical timing.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ceil(log2(v)), never less than 1 so it is always a usable width
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // clock cycles per line bit (integer division; caller keeps it >= 2)
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small circular byte FIFO in front of the UART transmitter.
// A push while full is dropped; a pop while empty is ignored.
`timescale 1ns/1ps
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // full blocks the write even if a pop frees a slot this same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, 8N1-style serialiser.
// Line and busy are registered from the FSM state, so both lag the state by one
// cycle; that keeps the frame exactly (1+PAYLOAD+STOP)*CPB cycles on the pin.
`timescale 1ns/1ps
module uart_tx_buffered import uart_pkg::*; #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [PAYLOAD_BITS-1:0]    tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx_busy,
  output logic [clog2(FIFO_DEPTH):0] fifo_count,
  output logic                       uart_txd
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int TW  = clog2(CPB);
  localparam int BW  = clog2(PAYLOAD_BITS) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);
  localparam logic [BW-1:0] D_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  logic [1:0]              state;
  logic [TW-1:0]           timer;
  logic [BW-1:0]           bcnt;
  logic [PAYLOAD_BITS-1:0] shift, fifo_rdata;
  logic                    fifo_full, fifo_empty, pop, bit_end;
  logic                    txd_q, busy_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PAYLOAD_BITS)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_valid),
    .wdata  (tx_data),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = busy_q;
  assign uart_txd = txd_q;
  assign bit_end  = (timer == T_LAST);
  // pop from idle, or on the final cycle of the last stop bit for a zero-gap restart
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || (state == ST_STOP && bit_end && bcnt == S_LAST));

  // frame sequencer: state, bit timer (cleared on every state entry), bit count, shifter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      timer <= '0;
      bcnt  <= '0;
      shift <= '0;
    end else if (pop) begin
      shift <= fifo_rdata;
      state <= ST_START;
      timer <= '0;
      bcnt  <= '0;
    end else begin
      case (state)
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            timer <= '0;
            bcnt  <= '0;
          end else timer <= timer + TW'(1);
        end
        ST_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            timer <= '0;
            if (bcnt == D_LAST) begin
              state <= ST_STOP;
              bcnt  <= '0;
            end else bcnt <= bcnt + BW'(1);
          end else timer <= timer + TW'(1);
        end
        ST_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (bcnt == S_LAST) begin
              state <= ST_IDLE;
              bcnt  <= '0;
            end else bcnt <= bcnt + BW'(1);
          end else timer <= timer + TW'(1);
        end
        default: timer <= '0;
      endcase
    end
  end

  // registered line and busy; reset forces the line high immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txd_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_START: txd_q <= 1'b0;
        ST_DATA:  txd_q <= shift[0];
        default:  txd_q <= 1'b1;
      endcase
      busy_q <= (state != ST_IDLE);
    end
  end

endmodule
